// File: rtl/me_integer_ctrl.sv
// rtl/me_integer_ctrl.sv - integer-pel ME sequencer and best-match selector
// Drives the address generator through clear/template/search phases and picks the minimum-SAD vector.
module me_integer_ctrl #(
  parameter int TB_LEN    = 256,
  parameter int SW_ROWS   = 18,
  parameter int SW_COLS   = 18,
  parameter int CAND_H    = 3,
  parameter int NUM_CAND  = 9,
  parameter int SAD_W     = 16,
  parameter int DRAIN_MAX = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [11:0]      init_mvec,
  input  logic             sad_valid,
  input  logic [SAD_W-1:0] sad_in,
  output logic             clr,
  output logic             en_tb,
  output logic             en_sw,
  output logic [11:0]      mvec_base,
  output logic             busy,
  output logic             done,
  output logic [11:0]      best_mvec,
  output logic [SAD_W-1:0] best_sad,
  output logic             timeout_err
);

  localparam int SW_LEN  = SW_ROWS * SW_COLS;
  localparam int MAX_A   = (TB_LEN > SW_LEN) ? TB_LEN : SW_LEN;
  localparam int CNT_MAX = (MAX_A > DRAIN_MAX) ? MAX_A : DRAIN_MAX;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int IDX_W   = $clog2(NUM_CAND + 1);

  localparam logic [CNT_W-1:0] TB_LAST    = CNT_W'(TB_LEN - 1);
  localparam logic [CNT_W-1:0] SW_LAST    = CNT_W'(SW_LEN - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_MAX - 1);
  localparam logic [IDX_W-1:0] CAND_NUM   = IDX_W'(NUM_CAND);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_LOAD_TB, S_SEARCH, S_DRAIN, S_DONE
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               clr_q, en_tb_q, en_sw_q, busy_q, done_q, timeout_err_q;
  logic [11:0]        mvec_base_q, best_mvec_q;
  logic [SAD_W-1:0]   best_sad_q;
  logic [SAD_W-1:0]   run_sad_q;
  logic [IDX_W-1:0]   run_idx_q, cand_cnt_q;

  logic               sad_accept, sad_better;
  logic [SAD_W-1:0]   run_sad_d;
  logic [IDX_W-1:0]   run_idx_d, cand_cnt_d;
  logic [11:0]        result_mvec;
  int                 idx_i, dw_i, dh_i;

  // Running minimum including a SAD accepted this cycle, so DRAIN can finish on the same edge.
  always_comb begin
    sad_accept = sad_valid && (state_q == S_SEARCH || state_q == S_DRAIN) &&
                 (cand_cnt_q < CAND_NUM);
    sad_better = sad_accept && (sad_in < run_sad_q);
    run_sad_d  = sad_better ? sad_in : run_sad_q;
    run_idx_d  = sad_better ? cand_cnt_q : run_idx_q;
    cand_cnt_d = sad_accept ? cand_cnt_q + 1'b1 : cand_cnt_q;
  end

  // Candidate index walks h fastest; each 6-bit field wraps independently.
  always_comb begin
    idx_i       = int'(run_idx_d);
    dw_i        = idx_i / CAND_H;
    dh_i        = idx_i % CAND_H;
    result_mvec = {mvec_base_q[11:6] + 6'(dw_i), mvec_base_q[5:0] + 6'(dh_i)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      clr_q         <= 1'b0;
      en_tb_q       <= 1'b0;
      en_sw_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      mvec_base_q   <= '0;
      best_mvec_q   <= '0;
      best_sad_q    <= '0;
      run_sad_q     <= '0;
      run_idx_q     <= '0;
      cand_cnt_q    <= '0;
    end else begin
      run_sad_q  <= run_sad_d;
      run_idx_q  <= run_idx_d;
      cand_cnt_q <= cand_cnt_d;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            mvec_base_q   <= init_mvec;
            timeout_err_q <= 1'b0;
            clr_q         <= 1'b1;
            busy_q        <= 1'b1;
            state_q       <= S_CLR;
          end
        end
        S_CLR: begin
          clr_q      <= 1'b0;
          en_tb_q    <= 1'b1;
          cnt_q      <= '0;
          run_sad_q  <= '1;
          run_idx_q  <= '0;
          cand_cnt_q <= '0;
          state_q    <= S_LOAD_TB;
        end
        S_LOAD_TB: begin
          if (cnt_q == TB_LAST) begin
            en_tb_q <= 1'b0;
            en_sw_q <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_SEARCH;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_SEARCH: begin
          if (cnt_q == SW_LAST) begin
            en_sw_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_DRAIN;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DRAIN: begin
          if (cand_cnt_d == CAND_NUM || cnt_q == DRAIN_LAST) begin
            timeout_err_q <= (cand_cnt_d != CAND_NUM);
            done_q        <= 1'b1;
            best_mvec_q   <= result_mvec;
            best_sad_q    <= run_sad_d;
            state_q       <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign clr         = clr_q;
  assign en_tb       = en_tb_q;
  assign en_sw       = en_sw_q;
  assign mvec_base   = mvec_base_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign best_mvec   = best_mvec_q;
  assign best_sad    = best_sad_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_me_integer_ctrl.sv
// tb/tb_me_integer_ctrl.sv - scoreboard bench for me_integer_ctrl
module tb_me_integer_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] init_mvec = '0;
  logic        sad_valid = 1'b0;
  logic [15:0] sad_in = '0;
  logic        clr, en_tb, en_sw, busy, done, timeout_err;
  logic [11:0] mvec_base, best_mvec;
  logic [15:0] best_sad;

  me_integer_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .init_mvec(init_mvec),
    .sad_valid(sad_valid), .sad_in(sad_in), .clr(clr), .en_tb(en_tb),
    .en_sw(en_sw), .mvec_base(mvec_base), .busy(busy), .done(done),
    .best_mvec(best_mvec), .best_sad(best_sad), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] mvec;
    int          sad;
    bit          terr;
    int          drain;
    logic [11:0] base;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;
  int   n_clr = 0, n_tb = 0, n_sw = 0, n_drain = 0;
  bit   mb_bad = 1'b0;
  int   sads[10];
  int   gaps[10];

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Monitor: phase lengths, exclusivity and the result at each done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      n_clr = 0; n_tb = 0; n_sw = 0; n_drain = 0; mb_bad = 1'b0;
    end else begin
      chk("exclusive", (int'(clr) + int'(en_tb) + int'(en_sw)) <= 1 ? 1 : 0, 1);
      if (clr) chk("terr_cleared", int'(timeout_err), 0);
      if (clr) n_clr++;
      if (en_tb) n_tb++;
      if (en_sw) n_sw++;
      if (busy && !clr && !en_tb && !en_sw && !done && n_sw > 0) n_drain++;
      if (busy && sbq.size() > 0 && mvec_base != sbq[0].base) mb_bad = 1'b1;
      if (done) begin
        if (sbq.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("best_mvec", int'(best_mvec), int'(e.mvec));
          chk("best_sad", int'(best_sad), e.sad);
          chk("timeout_err", int'(timeout_err), int'(e.terr));
          chk("clr_len", n_clr, 1);
          chk("tb_len", n_tb, 256);
          chk("sw_len", n_sw, 324);
          chk("drain_len", n_drain, e.drain);
          chk("mvec_base", int'(mb_bad), 0);
          chk("busy_in_done", int'(busy), 1);
        end
        n_clr = 0; n_tb = 0; n_sw = 0; n_drain = 0; mb_bad = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sw(input logic want, input string name);
    int i = 0;
    while (en_sw !== want && i < 1000) begin
      tick();
      i++;
    end
    if (i >= 1000) chk(name, 0, 1);
  endtask

  task automatic deliver(input int n);
    for (int k = 0; k < n; k++) begin
      repeat (gaps[k]) tick();
      sad_valid = 1'b1;
      sad_in    = 16'(sads[k]);
      tick();
      sad_valid = 1'b0;
      sad_in    = 16'($urandom);
    end
  endtask

  // Reference: minimum over received SADs, earliest index on ties, offsets wrap mod 64.
  task automatic run(input logic [11:0] mv, input int n, input bit in_search,
                     input bit stray, input bit extra);
    exp_t e;
    int mn, idx, w, h, i;
    mn = 65535;
    for (int k = 0; k < n; k++) if (sads[k] < mn) mn = sads[k];
    idx = 0;
    for (int k = n - 1; k >= 0; k--) if (sads[k] == mn) idx = k;
    w = (int'(mv[11:6]) + idx / 3) % 64;
    h = (int'(mv[5:0]) + idx % 3) % 64;
    e.mvec = 12'(w * 64 + h);
    e.sad  = mn;
    e.terr = (n < 9);
    e.base = mv;
    if (n < 9) e.drain = 64;
    else if (in_search) e.drain = 1;
    else begin
      e.drain = 9;
      for (int k = 0; k < 9; k++) e.drain += gaps[k];
    end
    sbq.push_back(e);

    start = 1'b1;
    init_mvec = mv;
    tick();
    start = 1'b0;
    init_mvec = 12'($urandom);
    if (stray) begin
      i = 0;
      while (!en_tb && i < 20) begin tick(); i++; end
      repeat (20) tick();
      start = 1'b1;
      init_mvec = ~mv;
      sad_valid = 1'b1;
      sad_in = 16'd0;
      tick();
      start = 1'b0;
      sad_valid = 1'b0;
    end
    wait_sw(1'b1, "sw_rise");
    if (in_search) begin
      repeat (100) tick();
      deliver(n);
    end
    wait_sw(1'b0, "sw_fall");
    if (!in_search) deliver(n);
    if (extra) begin
      sad_valid = 1'b1;
      sad_in = 16'd0;
      tick();
      sad_valid = 1'b0;
    end
    i = 0;
    while (busy && i < 200) begin tick(); i++; end
    if (i >= 200) chk("done_wait", 0, 1);
    chk("sb_drained", sbq.size(), 0);
    tick();
  endtask

  task automatic fill_rand(input int gmax);
    for (int k = 0; k < 10; k++) begin
      sads[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535))
                                            : int'($urandom_range(0, 40));
      gaps[k] = int'($urandom_range(0, gmax));
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit srch;
    int n;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    @(negedge clk);
    chk("rst_clr", int'(clr), 0);
    chk("rst_en_tb", int'(en_tb), 0);
    chk("rst_en_sw", int'(en_sw), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_best_mvec", int'(best_mvec), 0);
    chk("rst_best_sad", int'(best_sad), 0);
    chk("rst_terr", int'(timeout_err), 0);
    tick();

    // Tie at k=3/4, results in DRAIN back-to-back.
    sads[0:8] = '{900, 800, 850, 700, 700, 950, 990, 999, 1000};
    for (int k = 0; k < 10; k++) gaps[k] = 0;
    run({6'd10, 6'd20}, 9, 1'b0, 1'b0, 1'b0);

    // Minimum at k=8 from a near-wrap origin.
    fill_rand(3);
    for (int k = 0; k < 9; k++) sads[k] = 100 + int'($urandom_range(0, 400));
    sads[8] = 5;
    run({6'd63, 6'd62}, 9, 1'b0, 1'b0, 1'b0);

    // Only five SADs: timeout with partial best.
    sads[0:4] = '{40, 30, 30, 60, 35};
    run({6'd5, 6'd7}, 5, 1'b0, 1'b0, 1'b0);
    chk("terr_hold", int'(timeout_err), 1);

    // No SADs at all.
    run({6'd33, 6'd1}, 0, 1'b0, 1'b0, 1'b0);

    // Stray start and SAD in LOAD_TB, 10th SAD in DRAIN.
    fill_rand(5);
    run(12'($urandom), 9, 1'b1, 1'b1, 1'b1);

    // Reset mid-SEARCH.
    start = 1'b1;
    init_mvec = 12'hABC;
    tick();
    start = 1'b0;
    wait_sw(1'b1, "abort_sw");
    repeat (50) tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_clr", int'(clr), 0);
    chk("abort_en_tb", int'(en_tb), 0);
    chk("abort_en_sw", int'(en_sw), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_mvec_base", int'(mvec_base), 0);
    chk("abort_best_mvec", int'(best_mvec), 0);
    chk("abort_best_sad", int'(best_sad), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) tick();
    chk("abort_idle", int'(busy), 0);

    fill_rand(3);
    run({6'd10, 6'd20}, 9, 1'b0, 1'b0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      srch = 1'($urandom_range(0, 1));
      fill_rand(srch ? 5 : 3);
      n = (!srch && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : 9;
      run(12'($urandom), n, srch, 1'b0, srch);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/me_integer_ctrl.md
Name: me_integer_ctrl

Overview:
Sequencer and best-match selector for the integer-pel motion estimation stage. On start it clears the address generator and streams the 16x16 template block through it with en_tb. It then sweeps the 18x18 search window with en_sw. It collects the 9 candidate SADs (3x3 positions) from the PE array and reports the minimum-SAD motion vector. It sits directly upstream of the integer address generator, driving its clr/en_tb/en_sw/init_mvec, and downstream of the SAD PE array.

Parameters:
TB_LEN, 256, template-load cycles (16x16 pixels)
SW_ROWS, 18, search-window rows per column (h direction)
SW_COLS, 18, search-window columns (w direction)
CAND_H, 3, candidate positions along h (SW_ROWS-16+1)
NUM_CAND, 9, candidates per search (CAND_H x (SW_COLS-16+1))
SAD_W, 16, SAD width
DRAIN_MAX, 64, max cycles waiting in DRAIN before timeout

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  single-cycle request; sampled only in IDLE
init_mvec  in  12  search origin {w[11:6], h[5:0]}
sad_valid  in  1  one candidate SAD present on sad_in
sad_in  in  SAD_W  candidate SAD; candidates arrive in order k=0..8, h fastest
clr  out  1  to address generator: synchronous clear
en_tb  out  1  to address generator: template address advance
en_sw  out  1  to address generator: search-window sweep enable
mvec_base  out  12  latched origin, to address generator init_mvec
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse, result valid
best_mvec  out  12  winning vector {w,h}; held until next done
best_sad  out  SAD_W  winning SAD; held until next done
timeout_err  out  1  set with done if fewer than NUM_CAND SADs arrived; cleared at next start

Behaviour:
- Reset: FSM=IDLE, and all outputs and counters are 0.
- All outputs are registered.
- FSM states: IDLE, CLR, LOAD_TB, SEARCH, DRAIN, DONE.
- IDLE: start=1 -> latch mvec_base<=init_mvec, clear timeout_err, go to CLR. start in any other state is ignored.
- CLR: exactly 1 cycle.
  - clr=1.
  - Internal best_sad_r <= all ones, best_idx <= 0, cand_cnt <= 0.
  - Next state LOAD_TB.
- LOAD_TB: en_tb=1 for exactly TB_LEN consecutive cycles (cycle counter 0..TB_LEN-1), then SEARCH.
- SEARCH:
  - en_sw=1 for exactly SW_ROWS*SW_COLS=324 consecutive cycles, then DRAIN.
  - en_sw is low in every state entered before SEARCH, so the address generator sees a rising edge on the first cycle and loads mvec_base.
- DRAIN: en_sw=0.
  - Go to DONE when cand_cnt==NUM_CAND, checked including a SAD accepted in the same cycle.
  - If DRAIN_MAX cycles elapse without that, go to DONE with timeout_err=1.
- DONE: exactly 1 cycle.
  - done=1.
  - best_mvec/best_sad are updated on entry and visible in this cycle.
  - Next state IDLE.
- SAD acceptance: only in SEARCH or DRAIN, and only while cand_cnt<NUM_CAND.
  - Otherwise sad_valid is ignored, including extra SADs and SADs arriving in IDLE/CLR/LOAD_TB/DONE.
- On an accepted SAD: if sad_in < best_sad_r (strict), then best_sad_r <= sad_in and best_idx <= cand_cnt. cand_cnt increments.
- Ties keep the earlier candidate (lower k).
- Result vector: dh = best_idx mod CAND_H, dw = best_idx div CAND_H.
  - best_mvec = {mvec_base[11:6]+dw, mvec_base[5:0]+dh}.
  - Each 6-bit field wraps modulo 64; no saturation.
- On timeout: best_mvec/best_sad reflect the candidates received so far. If none were received: best_sad=all ones, best_mvec=mvec_base.
- clr, en_tb and en_sw are mutually exclusive; no two are ever high in the same cycle.
- rst_n asserted mid-operation: immediate return to IDLE with all outputs 0. No done pulse.
- Total latency from the start cycle to done is 1+256+324+D+1 cycles, where D is the number of DRAIN cycles (≥1).

Test Plan:
1. Reset then idle 10 cycles -> clr/en_tb/en_sw/busy/done=0, best_mvec=0, best_sad=0.
2. start with init_mvec={6'd10,6'd20}:
   - clr high exactly 1 cycle, then en_tb high exactly 256 cycles, then en_sw high exactly 324 cycles.
   - mvec_base=12'h294 throughout.
3. Same as 2, with SADs 900,800,850,700,700,950,990,999,1000 sent during DRAIN:
   - done pulses 1 cycle after the 9th SAD.
   - best_sad=700, best_idx=3 (tie keeps k=3), best_mvec={11,20}.
4. init_mvec={63,62}, minimum at k=8 -> best_mvec={6'd1,6'd0}; the 6-bit fields wrap.
5. Only 5 SADs delivered -> done after 64 DRAIN cycles with timeout_err=1 and best among those 5. A following start clears timeout_err.
6. start pulsed during LOAD_TB, sad_valid in LOAD_TB, a 10th SAD in DRAIN, and rst_n low mid-SEARCH:
   - start and the stray SADs have no effect.
   - The reset returns to IDLE, all outputs are 0 and no done pulse occurs.
   - A fresh start afterwards completes normally.
